// File: rtl/mips_mc.sv
// Multi-cycle MIPS subset core (add/sub/ori/lui/lw/sw/beq/jal/jr/nop) with
// on-chip instruction and data memories and architectural-write trace ports.
module mips_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 1024,
  parameter int unsigned DM_DEPTH = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        imem_we,
  input  logic [$clog2(IM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                 imem_wdata,
  output logic [31:0]                 pc,
  output logic [2:0]                  state,
  output logic                        grf_we,
  output logic [4:0]                  grf_wa,
  output logic [31:0]                 grf_wd,
  output logic                        dm_we,
  output logic [31:0]                 dm_addr,
  output logic [31:0]                 dm_wd,
  output logic                        retire,
  output logic [31:0]                 retire_pc
);

  localparam int unsigned IM_AW = $clog2(IM_DEPTH);
  localparam int unsigned DM_AW = $clog2(DM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [31:0] r_pc, r_fpc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0] r_im  [IM_DEPTH];
  logic [31:0] r_dm  [DM_DEPTH];
  logic [31:0] r_grf [32];

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_alu, w_pc_off;
  logic [IM_AW-1:0] w_im_idx;
  logic [DM_AW-1:0] w_dm_idx;
  logic w_is_add, w_is_sub, w_is_ori, w_is_lui, w_is_lw, w_is_sw;
  logic w_is_beq, w_is_jal, w_is_jr;
  logic w_grf_we, w_dm_we, w_retire;
  logic [4:0]  w_grf_wa;
  logic [31:0] w_grf_wd;
  logic w_unused;

  assign w_op  = r_ir[31:26];
  assign w_rs  = r_ir[25:21];
  assign w_rt  = r_ir[20:16];
  assign w_rd  = r_ir[15:11];
  assign w_fn  = r_ir[5:0];
  assign w_imm = r_ir[15:0];
  assign w_sext = {{16{w_imm[15]}}, w_imm};

  assign w_is_add = (w_op == OP_RTYPE) && (w_fn == FN_ADD);
  assign w_is_sub = (w_op == OP_RTYPE) && (w_fn == FN_SUB);
  assign w_is_jr  = (w_op == OP_RTYPE) && (w_fn == FN_JR);
  assign w_is_ori = (w_op == OP_ORI);
  assign w_is_lui = (w_op == OP_LUI);
  assign w_is_lw  = (w_op == OP_LW);
  assign w_is_sw  = (w_op == OP_SW);
  assign w_is_beq = (w_op == OP_BEQ);
  assign w_is_jal = (w_op == OP_JAL);

  assign w_pc_off = r_pc - RESET_PC;
  assign w_im_idx = w_pc_off[IM_AW+1:2];
  assign w_dm_idx = r_alu[DM_AW+1:2];
  assign w_unused = ^{w_pc_off[31:IM_AW+2], w_pc_off[1:0]};

  always_comb begin
    w_alu = '0;
    if (w_is_add)               w_alu = r_a + r_b;
    else if (w_is_sub)          w_alu = r_a - r_b;
    else if (w_is_ori)          w_alu = r_a | {16'h0000, w_imm};
    else if (w_is_lui)          w_alu = {w_imm, 16'h0000};
    else if (w_is_lw || w_is_sw) w_alu = r_a + w_sext;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_grf_we = 1'b0;
    w_grf_wa = '0;
    w_grf_wd = '0;
    w_dm_we  = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_is_jal ? S_WB : S_EXEC;
      S_EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else if (w_is_add || w_is_sub || w_is_ori || w_is_lui) begin
          w_next = S_WB;
        end else begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_MEM: begin
        if (w_is_sw) begin
          w_dm_we  = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_grf_we = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
        if (w_is_jal) begin
          w_grf_wa = 5'd31;
          w_grf_wd = r_pc;
        end else if (w_is_lw) begin
          w_grf_wa = w_rt;
          w_grf_wd = r_mdr;
        end else if (w_is_ori || w_is_lui) begin
          w_grf_wa = w_rt;
          w_grf_wd = r_alu;
        end else begin
          w_grf_wa = w_rd;
          w_grf_wd = r_alu;
        end
      end
      default: w_next = S_FETCH;
    endcase
    // Nothing commits on an edge where reset is sampled low, so strobes drop with it.
    if (!reset) begin
      w_grf_we = 1'b0;
      w_dm_we  = 1'b0;
      w_retire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && imem_we) r_im[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_fpc <= RESET_PC;
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_alu <= '0;
      r_mdr <= '0;
      for (int unsigned i = 0; i < 32; i++)       r_grf[i] <= '0;
      for (int unsigned i = 0; i < DM_DEPTH; i++) r_dm[i]  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir  <= r_im[w_im_idx];
          r_fpc <= r_pc;
          r_pc  <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a <= r_grf[w_rs];
          r_b <= r_grf[w_rt];
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_is_beq && (r_a == r_b)) r_pc <= r_pc + {w_sext[29:0], 2'b00};
          if (w_is_jr)                  r_pc <= r_a;
        end
        S_MEM: begin
          if (w_dm_we) r_dm[w_dm_idx] <= r_b;
          else         r_mdr <= r_dm[w_dm_idx];
        end
        S_WB: begin
          if (w_is_jal) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        default: ;
      endcase
      if (w_grf_we && (w_grf_wa != 5'd0)) r_grf[w_grf_wa] <= w_grf_wd;
    end
  end

  assign pc        = r_pc;
  assign state     = r_state;
  assign grf_we    = w_grf_we;
  assign grf_wa    = w_grf_wa;
  assign grf_wd    = w_grf_wd;
  assign dm_we     = w_dm_we;
  assign dm_addr   = r_alu;
  assign dm_wd     = r_b;
  assign retire    = w_retire;
  assign retire_pc = r_fpc;

endmodule

// File: tb/tb_mips_mc.sv
// Directed bench for mips_mc: a straight-line instruction table plus
// hand-written branch, jump and reset-abandon sequences.
module tb_mips_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        retire;
  logic [31:0] retire_pc;

  mips_mc #(.RESET_PC(32'h0000_3000), .IM_DEPTH(1024), .DM_DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc(pc), .state(state),
    .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .retire(retire), .retire_pc(retire_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic        gwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [31:0] npc;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    imem_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] w);
    imem_addr  = a;
    imem_wdata = w;
    imem_we    = 1'b1;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    cyc      = 1;
    last_ret = 0;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input int lat, input logic gwe,
                              input logic [4:0] wa, input logic [31:0] wd, input logic dwe,
                              input logic [31:0] da, input logic [31:0] dwd,
                              input logic [31:0] npc);
    vec_t v;
    v.instr = instr; v.lat = lat; v.gwe = gwe; v.wa = wa; v.wd = wd;
    v.dwe = dwe; v.da = da; v.dwd = dwd; v.npc = npc;
    return v;
  endfunction

  // Waits (bounded) for the next retire pulse and checks everything committed with it.
  task automatic apply_vec(input string tag, input vec_t v, input logic [31:0] rpc);
    int n;
    n = 0;
    while (retire !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_retire"}, 32'(retire), 32'd1);
    check({tag, "_latency"}, 32'(cyc - last_ret), 32'(v.lat));
    last_ret = cyc;
    check({tag, "_retire_pc"}, retire_pc, rpc);
    check({tag, "_grf_we"}, 32'(grf_we), 32'(v.gwe));
    if (v.gwe) begin
      check({tag, "_grf_wa"}, 32'(grf_wa), 32'(v.wa));
      check({tag, "_grf_wd"}, grf_wd, v.wd);
    end
    check({tag, "_dm_we"}, 32'(dm_we), 32'(v.dwe));
    if (v.dwe) begin
      check({tag, "_dm_addr"}, dm_addr, v.da);
      check({tag, "_dm_wd"}, dm_wd, v.dwd);
    end
    tick();
    check({tag, "_next_pc"}, pc, v.npc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[21];
    vec_t vd[5];
    int   n;

    vt[0]  = mk(enc_i(6'h0D, 0, 1, 16'h1234), 4, 1, 1,  32'h0000_1234, 0, 0, 0, 32'h3004);
    vt[1]  = mk(enc_i(6'h0D, 0, 2, 16'h0001), 4, 1, 2,  32'h0000_0001, 0, 0, 0, 32'h3008);
    vt[2]  = mk(enc_r(1, 2, 3, 6'h20),        4, 1, 3,  32'h0000_1235, 0, 0, 0, 32'h300C);
    vt[3]  = mk(enc_i(6'h0F, 0, 5, 16'hFFFF), 4, 1, 5,  32'hFFFF_0000, 0, 0, 0, 32'h3010);
    vt[4]  = mk(enc_i(6'h0D, 5, 5, 16'hFFFF), 4, 1, 5,  32'hFFFF_FFFF, 0, 0, 0, 32'h3014);
    vt[5]  = mk(enc_i(6'h0D, 0, 6, 16'h0001), 4, 1, 6,  32'h0000_0001, 0, 0, 0, 32'h3018);
    vt[6]  = mk(enc_r(5, 6, 7, 6'h20),        4, 1, 7,  32'h0000_0000, 0, 0, 0, 32'h301C);
    vt[7]  = mk(enc_r(0, 6, 8, 6'h22),        4, 1, 8,  32'hFFFF_FFFF, 0, 0, 0, 32'h3020);
    vt[8]  = mk(enc_i(6'h0F, 0, 9, 16'hDEAD), 4, 1, 9,  32'hDEAD_0000, 0, 0, 0, 32'h3024);
    vt[9]  = mk(enc_i(6'h0D, 9, 9, 16'hBEEF), 4, 1, 9,  32'hDEAD_BEEF, 0, 0, 0, 32'h3028);
    vt[10] = mk(enc_i(6'h2B, 0, 9, 16'h0008), 4, 0, 0,  0, 1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h302C);
    vt[11] = mk(enc_i(6'h23, 0, 4, 16'h0008), 5, 1, 4,  32'hDEAD_BEEF, 0, 0, 0, 32'h3030);
    vt[12] = mk(enc_i(6'h2B, 9, 1, 16'hFFFF), 4, 0, 0,  0, 1, 32'hDEAD_BEEE, 32'h0000_1234, 32'h3034);
    vt[13] = mk(enc_i(6'h23, 0, 10, 16'h0EEC), 5, 1, 10, 32'h0000_1234, 0, 0, 0, 32'h3038);
    vt[14] = mk(enc_i(6'h04, 1, 0, 16'h0004), 3, 0, 0,  0, 0, 0, 0, 32'h303C);
    vt[15] = mk(enc_r(1, 2, 0, 6'h20),        4, 1, 0,  32'h0000_1235, 0, 0, 0, 32'h3040);
    vt[16] = mk(enc_r(0, 0, 11, 6'h20),       4, 1, 11, 32'h0000_0000, 0, 0, 0, 32'h3044);
    vt[17] = mk(32'hFC00_0000,                3, 0, 0,  0, 0, 0, 0, 32'h3048);
    vt[18] = mk(32'h0000_0000,                3, 0, 0,  0, 0, 0, 0, 32'h304C);
    vt[19] = mk(enc_i(6'h04, 0, 0, 16'h0000), 3, 0, 0,  0, 0, 0, 0, 32'h3050);
    vt[20] = mk(enc_r(6, 5, 12, 6'h22),       4, 1, 12, 32'h0000_0002, 0, 0, 0, 32'h3054);

    reset = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    do_reset();
    check("rst_pc", pc, 32'h3000);
    check("rst_state", 32'(state), 32'd0);
    check("rst_grf_we", 32'(grf_we), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);

    for (int i = 0; i < 21; i++) load(10'(i), vt[i].instr);
    release_reset();
    for (int i = 0; i < 21; i++)
      apply_vec($sformatf("v%0d", i), vt[i], 32'h3000 + 32'(4 * i));

    // beq $0,$0,-1 spins on its own address every 3 cycles
    do_reset();
    load(10'd0, enc_i(6'h04, 0, 0, 16'hFFFF));
    release_reset();
    for (int i = 0; i < 3; i++)
      apply_vec($sformatf("loop%0d", i), mk(32'h0, 3, 0, 0, 0, 0, 0, 0, 32'h3000), 32'h3000);

    // jal 0x3100 from 0x3008, jr $31 back to 0x300C
    do_reset();
    load(10'd0, 32'h0);
    load(10'd1, 32'h0);
    load(10'd2, {6'h03, 26'h000_0C40});
    load(10'd3, enc_i(6'h0D, 0, 13, 16'h0055));
    load(10'd64, enc_r(31, 0, 0, 6'h08));
    release_reset();
    apply_vec("j_nop0", mk(32'h0, 3, 0, 0, 0, 0, 0, 0, 32'h3004), 32'h3000);
    apply_vec("j_nop1", mk(32'h0, 3, 0, 0, 0, 0, 0, 0, 32'h3008), 32'h3004);
    apply_vec("j_jal",  mk(32'h0, 3, 1, 31, 32'h300C, 0, 0, 0, 32'h3100), 32'h3008);
    apply_vec("j_jr",   mk(32'h0, 3, 0, 0, 0, 0, 0, 0, 32'h300C), 32'h3100);
    apply_vec("j_ori",  mk(32'h0, 4, 1, 13, 32'h55, 0, 0, 0, 32'h3010), 32'h300C);

    // reset during sw's MEM cycle, with a stray IM write attempted while running
    do_reset();
    load(10'd0, enc_i(6'h0D, 0, 1, 16'h0077));
    load(10'd1, enc_i(6'h2B, 0, 1, 16'h0010));
    load(10'd2, enc_i(6'h23, 0, 2, 16'h0010));
    load(10'd3, enc_i(6'h23, 0, 3, 16'h0008));
    load(10'd4, enc_r(9, 0, 4, 6'h20));
    vd[0] = mk(32'h0, 4, 1, 1, 32'h77, 0, 0, 0, 32'h3004);
    vd[1] = mk(32'h0, 4, 0, 0, 0, 1, 32'h10, 32'h77, 32'h3008);
    vd[2] = mk(32'h0, 5, 1, 2, 32'h77, 0, 0, 0, 32'h300C);
    vd[3] = mk(32'h0, 5, 1, 3, 32'h0, 0, 0, 0, 32'h3010);
    vd[4] = mk(32'h0, 4, 1, 4, 32'h0, 0, 0, 0, 32'h3014);
    release_reset();
    imem_addr = 10'd1; imem_wdata = 32'h0; imem_we = 1'b1;
    apply_vec("d_pre_ori", vd[0], 32'h3000);
    n = 0;
    while (state !== 3'd3 && n < 10) begin
      tick();
      n++;
    end
    check("d_reach_mem", 32'(state), 32'd3);
    reset = 1'b0; imem_we = 1'b0;
    #1;
    check("d_abort_dm_we", 32'(dm_we), 32'd0);
    check("d_abort_retire", 32'(retire), 32'd0);
    tick();
    check("d_abort_pc", pc, 32'h3000);
    check("d_abort_state", 32'(state), 32'd0);
    check("d_abort_dm_we2", 32'(dm_we), 32'd0);
    tick();
    release_reset();
    for (int i = 0; i < 5; i++)
      apply_vec($sformatf("d%0d", i), vd[i], 32'h3000 + 32'(4 * i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
